// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Optional feature macro used by the top level: STALL_PERF_CNT_EN.
package pipeline_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_t;

    // Architectural $zero register specifier; never a real hazard source.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default EX-stage occupancy of a mult/div, in cycles.
    localparam int DEFAULT_MULDIV_LAT = 32;

    // Width of the stall-cycle performance counter.
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/muldiv_busy_timer.sv
// Mult/div occupancy tracker: IDLE/BUSY state machine, busy down-counter
// and a one-cycle completion pulse issued after the unit returns to IDLE.
module muldiv_busy_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = DEFAULT_MULDIV_LAT,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    muldiv_state_t    state;
    logic [CNT_W-1:0] timer;

    // Occupancy FSM: load LAT-1 on accept, count down to 0, then pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        timer <= CNT_W'(MULDIV_LAT - 1);
                    end
                end
                BUSY: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges load-use,
// taken-branch and mult/div structural hazards into PC / IF-ID / ID-EX
// controls. Outputs are combinational so a stall acts in the hazard cycle.
// Optional stall-cycle counter enabled by macro STALL_PERF_CNT_EN.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = DEFAULT_MULDIV_LAT,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_ex_memread,
    input  logic [REG_ADDR_W-1:0]  id_ex_regrt,
    input  logic [REG_ADDR_W-1:0]  if_id_regrs,
    input  logic [REG_ADDR_W-1:0]  if_id_regrt,
    input  logic                   branch_taken,
    input  logic                   id_is_muldiv,
    input  logic                   id_reads_hilo,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   ctrl_zero,
    output logic                   muldiv_busy,
    output logic                   muldiv_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic load_use;
    logic hilo_hazard;
    logic stall;
    logic accept_muldiv;

    assign load_use = id_ex_memread
                   && (id_ex_regrt != REG_ADDR_W'(REG_ZERO))
                   && ((id_ex_regrt == if_id_regrs) || (id_ex_regrt == if_id_regrt));

    assign hilo_hazard   = muldiv_busy && (id_reads_hilo || id_is_muldiv);
    assign stall         = load_use || hilo_hazard;

    // A squashed ID instruction must not start the unit.
    assign accept_muldiv = id_is_muldiv && !stall && !branch_taken;

    muldiv_busy_timer #(
        .MULDIV_LAT (MULDIV_LAT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (accept_muldiv),
        .busy  (muldiv_busy),
        .done  (muldiv_done)
    );

    // Priority mux: flush beats stall beats normal flow.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        ctrl_zero   = 1'b0;
        if (branch_taken) begin
            if_id_flush = 1'b1;
            ctrl_zero   = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ctrl_zero   = 1'b1;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Count real stall cycles (not branch-squashed ones), saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !branch_taken && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with MULDIV_LAT=4.
module tb_pipeline_stall_controller;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_ex_memread = 1'b0;
    logic [4:0]  id_ex_regrt = '0;
    logic [4:0]  if_id_regrs = '0;
    logic [4:0]  if_id_regrt = '0;
    logic        branch_taken = 1'b0;
    logic        id_is_muldiv = 1'b0;
    logic        id_reads_hilo = 1'b0;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        ctrl_zero;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [15:0] stall_cycles;

    pipeline_stall_controller #(
        .REG_ADDR_W (5),
        .MULDIV_LAT (LAT),
        .CNT_W      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_ex_memread (id_ex_memread),
        .id_ex_regrt   (id_ex_regrt),
        .if_id_regrs   (if_id_regrs),
        .if_id_regrt   (if_id_regrt),
        .branch_taken  (branch_taken),
        .id_is_muldiv  (id_is_muldiv),
        .id_reads_hilo (id_reads_hilo),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .ctrl_zero     (ctrl_zero),
        .muldiv_busy   (muldiv_busy),
        .muldiv_done   (muldiv_done),
        .stall_cycles  (stall_cycles)
    );

    // clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy_left: cycles of occupancy still ahead (including the current one).
    int          busy_left = 0;
    logic        done_flag = 1'b0;
    logic [15:0] cnt_m = '0;

    function automatic logic m_load_use();
        return id_ex_memread && (id_ex_regrt != 5'd0) &&
               ((id_ex_regrt == if_id_regrs) || (id_ex_regrt == if_id_regrt));
    endfunction

    function automatic logic m_stall(input logic busy_now);
        return m_load_use() || (busy_now && (id_reads_hilo || id_is_muldiv));
    endfunction

    // model state advance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_left = 0;
            done_flag = 1'b0;
            cnt_m     = '0;
        end else begin
            logic st;
            st = m_stall(busy_left > 0);
`ifdef STALL_PERF_CNT_EN
            if (st && !branch_taken && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
            done_flag = 1'b0;
            if (busy_left > 0) begin
                busy_left = busy_left - 1;
                if (busy_left == 0) done_flag = 1'b1;
            end else if (id_is_muldiv && !st && !branch_taken) begin
                busy_left = LAT;
            end
        end
    end

    // compare process: every negedge, all outputs
    always @(negedge clk) begin
        logic eb, ed, st, epc, eifw, efl, ecz;
        logic [15:0] ec;
        eb = !rst && (busy_left > 0);
        ed = !rst && done_flag;
        ec = rst ? 16'd0 : cnt_m;
        st = m_stall(eb);
        epc = 1'b1; eifw = 1'b1; efl = 1'b0; ecz = 1'b0;
        if (branch_taken) begin
            efl = 1'b1; ecz = 1'b1;
        end else if (st) begin
            epc = 1'b0; eifw = 1'b0; ecz = 1'b1;
        end
        chk("m_pc_write", {15'd0, pc_write}, {15'd0, epc});
        chk("m_if_id_write", {15'd0, if_id_write}, {15'd0, eifw});
        chk("m_if_id_flush", {15'd0, if_id_flush}, {15'd0, efl});
        chk("m_ctrl_zero", {15'd0, ctrl_zero}, {15'd0, ecz});
        chk("m_busy", {15'd0, muldiv_busy}, {15'd0, eb});
        chk("m_done", {15'd0, muldiv_done}, {15'd0, ed});
        chk("m_stall_cycles", stall_cycles, ec);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic md, input logic hl);
        id_ex_memread = mr;
        id_ex_regrt   = xrt;
        if_id_regrs   = rs;
        if_id_regrt   = rt;
        branch_taken  = br;
        id_is_muldiv  = md;
        id_reads_hilo = hl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic act, input logic exp);
        chk(name, {15'd0, act}, {15'd0, exp});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        rst = 1'b1;
        #8;
        lit("rst_pc_write", pc_write, 1'b1);
        lit("rst_if_id_write", if_id_write, 1'b1);
        lit("rst_flush", if_id_flush, 1'b0);
        lit("rst_ctrl_zero", ctrl_zero, 1'b0);
        lit("rst_busy", muldiv_busy, 1'b0);
        lit("rst_done", muldiv_done, 1'b0);
        chk("rst_stall_cycles", stall_cycles, 16'd0);
        next();
        rst = 1'b0;
        next();

        // load-use on rs
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        lit("lu_pc_write", pc_write, 1'b0);
        lit("lu_if_id_write", if_id_write, 1'b0);
        lit("lu_ctrl_zero", ctrl_zero, 1'b1);
        next();
        idle();
        #2;
        lit("lu_after_pc_write", pc_write, 1'b1);
        lit("lu_after_ctrl_zero", ctrl_zero, 1'b0);
        next();

        // $zero never hazards
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        lit("zero_pc_write", pc_write, 1'b1);
        lit("zero_ctrl_zero", ctrl_zero, 1'b0);
        next();

        // branch beats load-use (on rt)
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        #2;
        lit("br_flush", if_id_flush, 1'b1);
        lit("br_ctrl_zero", ctrl_zero, 1'b1);
        lit("br_pc_write", pc_write, 1'b1);
        lit("br_if_id_write", if_id_write, 1'b1);
        next();

        // single mult/div, mfhi during busy
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #2;
        lit("md_accept_busy", muldiv_busy, 1'b0);
        lit("md_accept_pc", pc_write, 1'b1);
        next();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LAT; i++) begin
            #2;
            lit("md_busy_window", muldiv_busy, 1'b1);
            lit("md_hilo_stall", pc_write, 1'b0);
            next();
        end
        #2;
        lit("md_busy_fell", muldiv_busy, 1'b0);
        lit("md_done_pulse", muldiv_done, 1'b1);
        lit("md_hilo_released", pc_write, 1'b1);
        next();
        idle();
        #2;
        lit("md_done_cleared", muldiv_done, 1'b0);
        next();

        // back-to-back mult/div
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        next();
        for (int i = 0; i < LAT; i++) begin
            #2;
            lit("b2b_second_stalled", pc_write, 1'b0);
            next();
        end
        #2;
        lit("b2b_idle_gap", muldiv_busy, 1'b0);
        lit("b2b_accept_pc", pc_write, 1'b1);
        next();
        idle();
        for (int i = 0; i < LAT; i++) begin
            #2;
            lit("b2b_second_busy", muldiv_busy, 1'b1);
            next();
        end
        #2;
        lit("b2b_second_done", muldiv_done, 1'b1);
        next();

        // reset mid-busy, after 3 counted stalls
        rst = 1'b1;
        next();
        rst = 1'b0;
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) next();
        idle();
        #2;
`ifdef STALL_PERF_CNT_EN
        chk("cnt_three_stalls", stall_cycles, 16'd3);
`else
        chk("cnt_tied_zero", stall_cycles, 16'd0);
`endif
        next();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        next();
        idle();
        #2;
        lit("rb_busy_cycle1", muldiv_busy, 1'b1);
        next();
        rst = 1'b1;
        #2;
        lit("rb_busy_cleared", muldiv_busy, 1'b0);
        lit("rb_no_done", muldiv_done, 1'b0);
        chk("rb_cnt_cleared", stall_cycles, 16'd0);
        next();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            #2;
            lit("rb_no_late_done", muldiv_done, 1'b0);
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
